// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan reader: segment codes (active-low {g..a}),
// capture record layout and FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h18;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] value;
    logic       blank;
    logic       err;
  } seg7_rec_t;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StDwell
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex->7-segment encoder: recovers the nibble from an active-low
// segment pattern, flagging all-off as blank and any unknown pattern as err.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] value_o,
  output logic       blank_o,
  output logic       err_o
);

  always_comb begin
    value_o = 4'h0;
    blank_o = 1'b0;
    err_o   = 1'b0;
    case (seg_i)
      SEG_HEX_0: value_o = 4'h0;
      SEG_HEX_1: value_o = 4'h1;
      SEG_HEX_2: value_o = 4'h2;
      SEG_HEX_3: value_o = 4'h3;
      SEG_HEX_4: value_o = 4'h4;
      SEG_HEX_5: value_o = 4'h5;
      SEG_HEX_6: value_o = 4'h6;
      SEG_HEX_7: value_o = 4'h7;
      SEG_HEX_8: value_o = 4'h8;
      SEG_HEX_9: value_o = 4'h9;
      SEG_HEX_A: value_o = 4'hA;
      SEG_HEX_B: value_o = 4'hB;
      SEG_HEX_C: value_o = 4'hC;
      SEG_HEX_D: value_o = 4'hD;
      SEG_HEX_E: value_o = 4'hE;
      SEG_HEX_F: value_o = 4'hF;
      SEG_BLANK: blank_o = 1'b1;
      default:   err_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Monitors a multiplexed active-low 7-segment bus and recovers one record per stable digit dwell.
// Optional decimal-point capture is enabled by defining SEG7_READER_DP_EN.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  localparam int unsigned IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
`ifdef SEG7_READER_DP_EN
  input  logic                    dp_in,
  output logic                    out_dp,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_idx,
  output logic [3:0]              out_value,
  output logic                    out_blank,
  output logic                    out_err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    frame_done,
  output logic                    ovf
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef SEG7_READER_DP_EN
  localparam int unsigned SMP_W = NUM_DIGITS + 8;
`else
  localparam int unsigned SMP_W = NUM_DIGITS + 7;
`endif

  logic [SMP_W-1:0]      smp_in, smp_q, prev_q;
  logic [NUM_DIGITS-1:0] s_sel;
  logic [6:0]            s_seg;
  logic                  smp_valid, smp_same;

`ifdef SEG7_READER_DP_EN
  logic s_dp;
  logic out_dp_q, out_dp_d;
  assign smp_in = {dig_sel, seg_in, dp_in};
  assign s_dp   = smp_q[0];
  assign out_dp = out_dp_q;
`else
  assign smp_in = {dig_sel, seg_in};
`endif

  assign s_sel     = smp_q[SMP_W-1 -: NUM_DIGITS];
  assign s_seg     = smp_q[SMP_W-NUM_DIGITS-1 -: 7];
  assign smp_valid = $onehot(s_sel);
  // prev_q holds the sample the FSM evaluated on the previous cycle
  assign smp_same  = (smp_q == prev_q);

  logic [3:0] dec_value;
  logic       dec_blank, dec_err;

  seg7_pattern_decode u_decode (
    .seg_i   (s_seg),
    .value_o (dec_value),
    .blank_o (dec_blank),
    .err_o   (dec_err)
  );

  logic [IDX_W-1:0] cap_idx;

  always_comb begin
    cap_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (s_sel[i]) cap_idx = IDX_W'(i);
    end
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (smp_valid) begin
          state_d = StSettle;
          cnt_d   = CNT_ONE;
        end
      end
      StSettle: begin
        if (!smp_valid) begin
          state_d = StIdle;
        end else if (!smp_same) begin
          cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          capture = 1'b1;
          state_d = StDwell;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      StDwell: begin
        if (!smp_valid) begin
          state_d = StIdle;
        end else if (!smp_same) begin
          state_d = StSettle;
          cnt_d   = CNT_ONE;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic                    valid_q, valid_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  seg7_rec_t               rec_q, rec_d;
  logic                    ovf_q, ovf_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_q, frame_d;

  always_comb begin
    valid_d  = valid_q;
    idx_d    = idx_q;
    rec_d    = rec_q;
    ovf_d    = ovf_q;
    digits_d = digits_q;
    seen_d   = seen_q;
    frame_d  = 1'b0;
`ifdef SEG7_READER_DP_EN
    out_dp_d = out_dp_q;
`endif
    if (capture) begin
      if (!valid_q || out_ready) begin
        valid_d = 1'b1;
        idx_d   = cap_idx;
        rec_d   = '{value: dec_value, blank: dec_blank, err: dec_err};
`ifdef SEG7_READER_DP_EN
        out_dp_d = ~s_dp;
`endif
      end else begin
        ovf_d = 1'b1;
      end
      // The snapshot tracks what is displayed even when the streamed record is dropped
      if (!dec_blank && !dec_err) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (IDX_W'(i) == cap_idx) begin
            digits_d[4*i +: 4] = dec_value;
            seen_d[i]          = 1'b1;
          end
        end
        if (&seen_d) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      smp_q    <= '0;
      prev_q   <= '0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      rec_q    <= '0;
      ovf_q    <= 1'b0;
      digits_q <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
`ifdef SEG7_READER_DP_EN
      out_dp_q <= 1'b0;
`endif
    end else begin
      smp_q    <= smp_in;
      prev_q   <= smp_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      rec_q    <= rec_d;
      ovf_q    <= ovf_d;
      digits_q <= digits_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
`ifdef SEG7_READER_DP_EN
      out_dp_q <= out_dp_d;
`endif
    end
  end

  assign out_valid  = valid_q;
  assign out_idx    = idx_q;
  assign out_value  = rec_q.value;
  assign out_blank  = rec_q.blank;
  assign out_err    = rec_q.err;
  assign digits     = digits_q;
  assign frame_done = frame_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: directed scenarios plus randomized scanning, all
// compared against a run-length reference model of the display bus.
module tb_seg7_scan_reader;

  localparam int ND = 4;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_sel = '0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_blank, out_err, frame_done, ovf;
  logic [1:0]  out_idx;
  logic [3:0]  out_value;
  logic [15:0] digits;
`ifdef SEG7_READER_DP_EN
  logic        dp_in = 1'b1;
  logic        out_dp;
`endif

  seg7_scan_reader #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seg_in     (seg_in),
    .dig_sel    (dig_sel),
`ifdef SEG7_READER_DP_EN
    .dp_in      (dp_in),
    .out_dp     (out_dp),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_value  (out_value),
    .out_blank  (out_blank),
    .out_err    (out_err),
    .digits     (digits),
    .frame_done (frame_done),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: a capture happens one edge after SC+1 identical valid samples were registered
  logic [10:0] m_last;
  int          m_run;
  bit          m_valid, m_blank, m_err, m_fd, m_ovf;
  int          m_idx;
  logic [3:0]  m_val;
  logic [15:0] m_digits;
  bit   [3:0]  m_seen;

  task automatic model_edge(input logic [3:0] sel, input logic [6:0] seg, input logic rdy,
                            input logic rst);
    bit   is_hex, is_blank;
    int   v, idx;
    if (rst) begin
      m_last = '0; m_run = 0; m_valid = 0; m_blank = 0; m_err = 0; m_fd = 0; m_ovf = 0;
      m_idx = 0; m_val = '0; m_digits = '0; m_seen = '0;
    end else begin
      m_fd = 0;
      if (m_run == SC + 1) begin
        is_hex = 0; v = 0; idx = 0;
        for (int j = 0; j < 16; j++) if (hex_tab[j] == m_last[6:0]) begin is_hex = 1; v = j; end
        for (int j = 0; j < ND; j++) if (m_last[7+j]) idx = j;
        is_blank = (m_last[6:0] == 7'h7F);
        if (!m_valid || rdy) begin
          m_valid = 1; m_idx = idx; m_val = is_hex ? 4'(v) : 4'h0;
          m_blank = is_blank; m_err = !is_hex && !is_blank;
        end else begin
          m_ovf = 1;
        end
        if (is_hex) begin
          m_digits[4*idx +: 4] = 4'(v);
          m_seen[idx] = 1'b1;
          if (m_seen == 4'hF) begin m_fd = 1; m_seen = '0; end
        end
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
      if ($countones(sel) == 1 && {sel, seg} == m_last && m_run > 0) m_run++;
      else m_run = ($countones(sel) == 1) ? 1 : 0;
      m_last = {sel, seg};
    end
  endtask

  task automatic tick(input logic [3:0] sel, input logic [6:0] seg, input logic rdy,
                      input logic rst);
    dig_sel = sel; seg_in = seg; out_ready = rdy; reset = rst;
    @(posedge clk);
    model_edge(sel, seg, rdy, rst);
    #1;
  endtask

  function automatic logic [26:0] dut_vec();
    return {out_valid, out_valid ? {out_idx, out_value, out_blank, out_err} : 8'h0,
            digits, frame_done, ovf};
  endfunction

  function automatic logic [26:0] mdl_vec();
    return {m_valid, m_valid ? {2'(m_idx), m_val, m_blank, m_err} : 8'h0,
            m_digits, m_fd, m_ovf};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(4'($urandom), 7'($urandom), 1'($urandom), 1'b1);
      total++;
      if (dut_vec() !== 27'h0) begin
        bad++; $display("FAIL reset cyc=%0d got=%h want=0", i, dut_vec());
      end
    end
  endtask

  task automatic test_basic();
    int recs = 0, first = -1;
    for (int i = 0; i < 10; i++) begin
      tick(4'b0001, 7'h24, 1'b1, 1'b0);
      if (out_valid) begin recs++; if (first < 0) first = i; end
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; $display("FAIL basic cyc=%0d got=%h want=%h", i, dut_vec(), mdl_vec());
      end
    end
    total++;
    if (recs !== 1 || first !== SC + 1) begin
      bad++; $display("FAIL basic_latency recs=%0d edge=%0d want recs=1 edge=%0d", recs, first, SC + 1);
    end
    total++;
    if (digits[3:0] !== 4'h2) begin
      bad++; $display("FAIL basic_digit got=%h want=2", digits[3:0]);
    end
  endtask

  task automatic test_settle();
    int recs = 0;
    for (int i = 0; i < 11; i++) begin
      tick(4'b0010, (i < 3) ? 7'h30 : 7'h19, 1'b1, 1'b0);
      if (out_valid) begin
        recs++;
        total++;
        if (out_idx !== 2'd1 || out_value !== 4'h4) begin
          bad++; $display("FAIL settle_rec got idx=%0d val=%h want idx=1 val=4", out_idx, out_value);
        end
      end
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; $display("FAIL settle cyc=%0d got=%h want=%h", i, dut_vec(), mdl_vec());
      end
    end
    total++;
    if (recs !== 1) begin bad++; $display("FAIL settle_count got=%0d want=1", recs); end
  endtask

  task automatic test_blank_err();
    int blanks = 0, errs = 0, others = 0;
    logic [6:0] pats [3] = '{7'h7F, 7'h55, 7'h40};
    logic [3:0] sels [3] = '{4'b0100, 4'b0100, 4'b0110};
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 7; i++) begin
        tick(sels[p], pats[p], 1'b1, 1'b0);
        if (out_valid && p == 0 && out_blank && out_value == 4'h0) blanks++;
        if (out_valid && p == 1 && out_err && out_value == 4'h0) errs++;
        if (out_valid && p == 2) others++;
        total++;
        if (dut_vec() !== mdl_vec()) begin
          bad++; $display("FAIL blank_err p=%0d cyc=%0d got=%h want=%h", p, i, dut_vec(), mdl_vec());
        end
      end
    end
    total++;
    if (blanks !== 1 || errs !== 1 || others !== 0) begin
      bad++; $display("FAIL blank_err_recs got blank=%0d err=%0d bad_sel=%0d want 1 1 0",
                      blanks, errs, others);
    end
    total++;
    if (digits[11:8] !== 4'h0) begin
      bad++; $display("FAIL blank_digit got=%h want=0", digits[11:8]);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 14; i++) begin
      tick(4'b1000, (i < 7) ? 7'h46 : 7'h21, 1'b0, 1'b0);
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; $display("FAIL overflow cyc=%0d got=%h want=%h", i, dut_vec(), mdl_vec());
      end
    end
    total++;
    if (!out_valid || out_idx !== 2'd3 || out_value !== 4'hC || ovf !== 1'b1) begin
      bad++; $display("FAIL overflow_hold got v=%b idx=%0d val=%h ovf=%b want 1 3 C 1",
                      out_valid, out_idx, out_value, ovf);
    end
    tick(4'b0000, 7'h7F, 1'b1, 1'b0);
    tick(4'b0000, 7'h7F, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b0 || ovf !== 1'b1) begin
      bad++; $display("FAIL overflow_sticky got v=%b ovf=%b want v=0 ovf=1", out_valid, ovf);
    end
  endtask

  task automatic test_scan();
    int fds = 0, recs = 0;
    logic [6:0] pats [4] = '{7'h00, 7'h12, 7'h79, 7'h40};
    tick(4'b0000, 7'h7F, 1'b0, 1'b1);
    tick(4'b0000, 7'h7F, 1'b0, 1'b1);
    for (int d = 0; d < 5; d++) begin
      for (int i = 0; i < 6; i++) begin
        if (d < 4) tick(4'(1 << d), pats[d], 1'b1, 1'b0);
        else tick(4'b0000, 7'h7F, 1'b1, 1'b0);
        if (frame_done) fds++;
        total++;
        if (dut_vec() !== mdl_vec()) begin
          bad++; $display("FAIL scan d=%0d cyc=%0d got=%h want=%h", d, i, dut_vec(), mdl_vec());
        end
      end
    end
    total++;
    if (digits !== 16'h0158 || fds !== 1) begin
      bad++; $display("FAIL scan_frame got digits=%h pulses=%0d want 0158 1", digits, fds);
    end
    tick(4'b0001, 7'h24, 1'b1, 1'b0);
    tick(4'b0001, 7'h24, 1'b1, 1'b0);
    tick(4'b0001, 7'h24, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(4'b0000, 7'h24, 1'b1, 1'b0);
      if (out_valid) recs++;
    end
    total++;
    if (recs !== 0 || digits !== 16'h0 || ovf !== 1'b0) begin
      bad++; $display("FAIL reset_settle got recs=%0d digits=%h ovf=%b want 0 0 0", recs, digits, ovf);
    end
  endtask

  task automatic test_random();
    logic [3:0] sel;
    logic [6:0] seg;
    int         dur, r;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70) sel = 4'(1 << $urandom_range(0, 3));
      else if (r < 85) sel = 4'h0;
      else sel = 4'($urandom);
      r = $urandom_range(0, 99);
      if (r < 60) seg = hex_tab[$urandom_range(0, 15)];
      else if (r < 75) seg = 7'h7F;
      else seg = 7'($urandom);
      dur = $urandom_range(1, 8);
      for (int i = 0; i < dur; i++) begin
        tick(sel, seg, ($urandom_range(0, 3) != 0), (i == 0 && $urandom_range(0, 99) == 0));
        total++;
        if (dut_vec() !== mdl_vec()) begin
          bad++; $display("FAIL random n=%0d cyc=%0d got=%h want=%h", n, i, dut_vec(), mdl_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_settle();
    test_blank_err();
    test_overflow();
    test_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
